// File: rtl/memctrl_host.sv
// memctrl_host: single-outstanding bus initiator that turns a valid/ready
// request into one MEMCTRL command cycle, waits out read latency or write
// recovery, then returns a one-cycle response.
//
// Ports:
//   clk, rstn                      clock (rising edge), async active-low reset
//   req_valid/req_ready            request handshake
//   req_we, req_addr, req_wdata    request payload (1=write)
//   rsp_valid, rsp_wr, rsp_rdata   one-cycle response pulse and payload
//   addr, ce, csb, idata, oeb, web MEMCTRL command pins (all registered)
//   odata                          MEMCTRL read data
module memctrl_host #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned WR_GAP = 1,
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic          rsp_wr,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] addr,
  output logic          ce,
  output logic          csb,
  output logic [DW-1:0] idata,
  output logic          oeb,
  output logic          web,
  input  logic [DW-1:0] odata
);

  localparam int unsigned CW = 3;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    CMD  = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            init_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            lat_we_q, lat_we_d;
  logic [AW-1:0]   lat_addr_q, lat_addr_d;
  logic [DW-1:0]   lat_wdata_q, lat_wdata_d;

  logic            req_ready_d;
  logic            rsp_valid_d;
  logic            rsp_wr_d;
  logic [DW-1:0]   rsp_rdata_d;
  logic [AW-1:0]   addr_d;
  logic            ce_d;
  logic            csb_d;
  logic [DW-1:0]   idata_d;
  logic            oeb_d;
  logic            web_d;

  // State, counter and latched request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= INIT;
      init_q      <= 1'b0;
      cnt_q       <= '0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      // Absorbs the partial cycle in which rstn deasserts so INIT spans a full clock.
      init_q      <= 1'b1;
      cnt_q       <= cnt_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
    end
  end

  // Next state, then output values decoded from the state being entered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_wr_d    = 1'b0;
    rsp_rdata_d = '0;
    addr_d      = addr;
    ce_d        = 1'b0;
    csb_d       = 1'b1;
    idata_d     = '0;
    oeb_d       = 1'b1;
    web_d       = 1'b1;

    unique case (state_q)
      INIT: begin
        if (init_q) state_d = IDLE;
      end
      IDLE: begin
        if (req_valid && req_ready) begin
          lat_we_d    = req_we;
          lat_addr_d  = req_addr;
          lat_wdata_d = req_wdata;
          state_d     = CMD;
        end
      end
      CMD: begin
        state_d = WAIT;
        cnt_d   = lat_we_q ? CW'(WR_GAP - 1) : CW'(RD_LAT - 1);
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
      end
    endcase

    unique case (state_d)
      IDLE: begin
        req_ready_d = 1'b1;
      end
      CMD: begin
        ce_d   = 1'b1;
        csb_d  = 1'b0;
        addr_d = lat_addr_d;
        if (lat_we_d) begin
          web_d   = 1'b0;
          idata_d = lat_wdata_d;
        end else begin
          oeb_d = 1'b0;
        end
      end
      RESP: begin
        // Entering RESP is the edge ending cycle CMD+RD_LAT: read data is sampled here.
        rsp_valid_d = 1'b1;
        rsp_wr_d    = lat_we_q;
        rsp_rdata_d = lat_we_q ? '0 : odata;
      end
      default: begin
      end
    endcase
  end

  // Registered outputs; reset forces the bus idle immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_rdata <= '0;
      addr      <= '0;
      ce        <= 1'b0;
      csb       <= 1'b1;
      idata     <= '0;
      oeb       <= 1'b1;
      web       <= 1'b1;
    end else begin
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_wr    <= rsp_wr_d;
      rsp_rdata <= rsp_rdata_d;
      addr      <= addr_d;
      ce        <= ce_d;
      csb       <= csb_d;
      idata     <= idata_d;
      oeb       <= oeb_d;
      web       <= web_d;
    end
  end

endmodule

// File: tb/tb_memctrl_host.sv
// tb_memctrl_host: directed bench for memctrl_host. One instance runs with
// RD_LAT=1/WR_GAP=1 against a banked memory model, a second runs with
// RD_LAT=3 against a model that presents read data only on cycle CMD+3.
module tb_memctrl_host;

  logic        clk;
  logic        rstn;

  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_wr;
  logic [7:0]  rsp_rdata;
  logic [15:0] addr;
  logic        ce, csb, oeb, web;
  logic [7:0]  idata, odata;

  logic        d3_req_valid, d3_req_ready, d3_req_we;
  logic [15:0] d3_req_addr;
  logic [7:0]  d3_req_wdata;
  logic        d3_rsp_valid, d3_rsp_wr;
  logic [7:0]  d3_rsp_rdata;
  logic [15:0] d3_addr;
  logic        d3_ce, d3_csb, d3_oeb, d3_web;
  logic [7:0]  d3_idata, d3_odata;

  int n_checks = 0;
  int n_fail   = 0;
  int ce_cnt   = 0;
  int rsp_cnt  = 0;

  memctrl_host #(.RD_LAT(1), .WR_GAP(1), .AW(16), .DW(8)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
    .addr(addr), .ce(ce), .csb(csb), .idata(idata), .oeb(oeb), .web(web),
    .odata(odata)
  );

  memctrl_host #(.RD_LAT(3), .WR_GAP(1), .AW(16), .DW(8)) dut3 (
    .clk(clk), .rstn(rstn),
    .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_we(d3_req_we),
    .req_addr(d3_req_addr), .req_wdata(d3_req_wdata),
    .rsp_valid(d3_rsp_valid), .rsp_wr(d3_rsp_wr), .rsp_rdata(d3_rsp_rdata),
    .addr(d3_addr), .ce(d3_ce), .csb(d3_csb), .idata(d3_idata), .oeb(d3_oeb), .web(d3_web),
    .odata(d3_odata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Banked memory for the RD_LAT=1 instance; read data valid only on cycle CMD+1.
  logic [7:0] mem [4];
  bit         m1_pend = 0;
  int         m1_age  = 0;
  logic [7:0] m1_data = 8'h00;
  always @(negedge clk) begin
    if (m1_pend) begin
      m1_age++;
      odata = (m1_age == 1) ? m1_data : 8'hEE;
      if (m1_age > 1) m1_pend = 0;
    end
    if (ce && !csb) begin
      if (!web) mem[addr[15:14]] = idata;
      if (!oeb) begin
        m1_pend = 1;
        m1_age  = 0;
        m1_data = mem[addr[15:14]];
      end
    end
  end

  // RD_LAT=3 instance: 8'h5A only on cycle CMD+3, garbage otherwise.
  bit d3_pend = 0;
  int d3_age  = 0;
  always @(negedge clk) begin
    if (d3_pend) begin
      d3_age++;
      d3_odata = (d3_age == 3) ? 8'h5A : 8'hEE;
      if (d3_age > 3) d3_pend = 0;
    end
    if (d3_ce && !d3_csb && !d3_oeb) begin
      d3_pend = 1;
      d3_age  = 0;
    end
  end

  always @(negedge clk) begin
    if (ce) ce_cnt++;
    if (rsp_valid) rsp_cnt++;
  end

  // One transaction on the RD_LAT=1 instance; checks command pins, latency, response.
  task automatic xact(input string tag, input logic we, input logic [15:0] a,
                      input logic [7:0] wd, input logic [7:0] exp_rd);
    bit got;
    int lat;
    int ce0;
    req_we = we; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    check({tag, "_hs"}, 32'(got), 32'd1);
    ce0 = ce_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = 8'h00;
    lat = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check({tag, "_cmd_ce"},    32'(ce),        32'd1);
        check({tag, "_cmd_csb"},   32'(csb),       32'd0);
        check({tag, "_cmd_web"},   32'(web),       32'(!we));
        check({tag, "_cmd_oeb"},   32'(oeb),       32'(we));
        check({tag, "_cmd_idata"}, 32'(idata),     we ? 32'(wd) : 32'd0);
        check({tag, "_cmd_addr"},  32'(addr),      32'(a));
        check({tag, "_cmd_ready"}, 32'(req_ready), 32'd0);
      end
      if (lat == 2) check({tag, "_wait_ce"}, 32'(ce), 32'd0);
      if (rsp_valid) got = 1;
    end
    check({tag, "_lat"},   32'(lat),       32'd3);
    check({tag, "_wr"},    32'(rsp_wr),    32'(we));
    check({tag, "_rdata"}, 32'(rsp_rdata), we ? 32'd0 : 32'(exp_rd));
    check({tag, "_ce_pulses"}, 32'(ce_cnt - ce0), 32'd1);
    @(negedge clk);
    check({tag, "_rsp_drop"},   32'(rsp_valid), 32'd0);
    check({tag, "_rdata_drop"}, 32'(rsp_rdata), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    int n;
    int ce0;
    int r0;
    logic [7:0] rd_data [4];
    logic [15:0] bank_addr [4];
    rd_data[0] = 8'h11; rd_data[1] = 8'h22; rd_data[2] = 8'h33; rd_data[3] = 8'h44;
    bank_addr[0] = 16'h0000; bank_addr[1] = 16'h4000;
    bank_addr[2] = 16'h8000; bank_addr[3] = 16'hC000;
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    odata = 8'hEE; d3_odata = 8'hEE;
    req_valid = 0; req_we = 0; req_addr = 16'h0; req_wdata = 8'h0;
    d3_req_valid = 0; d3_req_we = 0; d3_req_addr = 16'h0; d3_req_wdata = 8'h0;

    // Reset for 4 cycles; pins idle, not ready.
    rstn = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_ce",    32'(ce),        32'd0);
    check("rst_csb",   32'(csb),       32'd1);
    check("rst_oeb",   32'(oeb),       32'd1);
    check("rst_web",   32'(web),       32'd1);
    check("rst_addr",  32'(addr),      32'd0);
    check("rst_idata", 32'(idata),     32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp",   32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("init_ready_e0", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("init_ready_e1", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("init_ready_e2", 32'(req_ready), 32'd1);
    check("init_d3_ready", 32'(d3_req_ready), 32'd1);

    // Single write to bank 0 with A5.
    xact("wr_a5", 1'b1, 16'h0000, 8'hA5, 8'h00);

    // Write then read back every bank.
    for (int i = 0; i < 4; i++) xact($sformatf("wr_b%0d", i), 1'b1, bank_addr[i], rd_data[i], 8'h00);
    for (int i = 0; i < 4; i++) xact($sformatf("rd_b%0d", i), 1'b0, bank_addr[i], 8'h00, rd_data[i]);

    // Top address passes through unmodified.
    xact("wr_ffff", 1'b1, 16'hFFFF, 8'h77, 8'h00);
    xact("rd_ffff", 1'b0, 16'hFFFF, 8'h00, 8'h77);
    xact("rd_b0_again", 1'b0, 16'h0000, 8'h00, 8'h11);

    // RD_LAT=3 instance: read 4000, data present only on cycle CMD+3.
    d3_req_we = 1'b0; d3_req_addr = 16'h4000; d3_req_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (d3_req_ready) got = 1;
    end
    check("lat3_hs", 32'(got), 32'd1);
    @(posedge clk); #1;
    d3_req_valid = 1'b0;
    n = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("lat3_cmd_ce",    32'(d3_ce),    32'd1);
        check("lat3_cmd_csb",   32'(d3_csb),   32'd0);
        check("lat3_cmd_oeb",   32'(d3_oeb),   32'd0);
        check("lat3_cmd_web",   32'(d3_web),   32'd1);
        check("lat3_cmd_idata", 32'(d3_idata), 32'd0);
        check("lat3_cmd_addr",  32'(d3_addr),  32'h4000);
      end
      if (d3_rsp_valid) got = 1;
    end
    check("lat3_lat",   32'(n),            32'd5);
    check("lat3_wr",    32'(d3_rsp_wr),    32'd0);
    check("lat3_rdata", 32'(d3_rsp_rdata), 32'h5A);

    // Back-pressure: valid held high across two reads.
    req_we = 1'b0; req_addr = 16'h0000; req_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    check("bp_hs1", 32'(got), 32'd1);
    ce0 = ce_cnt;
    @(posedge clk); #1;
    req_addr = 16'h4000;
    n = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) check("bp_rsp1_rdata", 32'(rsp_rdata), 32'h11);
      if (req_ready) got = 1;
    end
    check("bp_hs2_gap", 32'(n), 32'd4);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) got = 1;
    end
    check("bp_rsp2_lat",   32'(n),         32'd3);
    check("bp_rsp2_rdata", 32'(rsp_rdata), 32'h22);
    check("bp_ce_pulses",  32'(ce_cnt - ce0), 32'd2);

    // Reset while the read sits in WAIT.
    @(negedge clk);
    req_we = 1'b0; req_addr = 16'h8000; req_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    check("mrst_hs", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    r0 = rsp_cnt;
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("mrst_ce",    32'(ce),        32'd0);
    check("mrst_csb",   32'(csb),       32'd1);
    check("mrst_oeb",   32'(oeb),       32'd1);
    check("mrst_rsp",   32'(rsp_valid), 32'd0);
    check("mrst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    check("mrst_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    xact("mrst_wr", 1'b1, 16'h8000, 8'h99, 8'h00);
    xact("mrst_rd", 1'b0, 16'h8000, 8'h00, 8'h99);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
